// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard.
//   fwd_t   : forward-select codes (register file, W stage, M stage).
//   stage_t : one mirrored pipeline stage {valid, dst, wr, load}.
//   stage_writes() : true when a stage holds a valid writer of register r.
// Register addresses are carried at STAGE_AW bits so the struct can live in a
// non-parameterised package; narrower REG_AW values are zero-extended.
package hazard_pkg;

  localparam int unsigned STAGE_AW = 8;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_t;

  typedef struct packed {
    logic                valid;
    logic [STAGE_AW-1:0] dst;
    logic                wr;
    logic                load;
  } stage_t;

  function automatic logic stage_writes(input stage_t s, input logic [STAGE_AW-1:0] r);
    return s.valid & s.wr & (s.dst == r);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One mirrored pipeline stage.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   hold  : keep current contents (stage stalled)
//   flush : load a bubble instead of d
//   d / q : incoming / held stage contents
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  logic   flush,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (!hold) begin
      q <= flush ? '0 : d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller for a 5-stage F/D/E/M/W pipeline.
// Keeps its own mirror of the E/M/W destinations and drives every stall,
// flush and forward-select line from that mirror plus the decode-stage info.
//   clk, reset (async active-low)
//   dec_valid, dec_src, dec_src_used, dec_dst, dec_wr, dec_load, dec_multi :
//     instruction currently in D
//   br_missed_e : mispredicted branch resolved in E
//   stall_f/d/e, flush_d/e : pipeline register control
//   fwd_sel     : per-source forward select for the instruction in E
//   multi_busy  : a multi-cycle op still occupies E
// MUL_LAT must be at least 2.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned NSRC    = 3,
  parameter int unsigned MUL_LAT = 3,
  parameter bit          FWD_EN  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dec_valid,
  input  logic [NSRC*REG_AW-1:0] dec_src,
  input  logic [NSRC-1:0]        dec_src_used,
  input  logic [REG_AW-1:0]      dec_dst,
  input  logic                   dec_wr,
  input  logic                   dec_load,
  input  logic                   dec_multi,
  input  logic                   br_missed_e,
  output logic                   stall_f,
  output logic                   stall_d,
  output logic                   stall_e,
  output logic                   flush_d,
  output logic                   flush_e,
  output logic [NSRC*2-1:0]      fwd_sel,
  output logic                   multi_busy
);

  localparam int unsigned CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  stage_t e_q, m_q, w_q, e_d;
  logic [NSRC*REG_AW-1:0] e_src;
  logic [NSRC-1:0]        e_used;
  logic [CNT_W-1:0]       cnt;
  logic                   busy;
  logic [NSRC-1:0]        lu_hit;
  logic [NSRC-1:0]        raw_hit;
  logic                   hazard;

  assign busy = (cnt != '0);

  // Per-slot comparators: decode-side hazards and E-side forward selects.
  for (genvar i = 0; i < NSRC; i++) begin : g_slot
    logic [STAGE_AW-1:0] d_reg;
    logic [STAGE_AW-1:0] e_reg;
    fwd_t                fwd_slot;

    assign d_reg = STAGE_AW'(dec_src[i*REG_AW +: REG_AW]);
    assign e_reg = STAGE_AW'(e_src[i*REG_AW +: REG_AW]);

    assign lu_hit[i]  = dec_valid & dec_src_used[i] & e_q.load & stage_writes(e_q, d_reg);
    assign raw_hit[i] = dec_valid & dec_src_used[i] &
                        (stage_writes(e_q, d_reg) | stage_writes(m_q, d_reg) |
                         stage_writes(w_q, d_reg));

    always_comb begin
      fwd_slot = FWD_RF;
      if (FWD_EN && e_q.valid && e_used[i]) begin
        if (stage_writes(m_q, e_reg)) begin
          fwd_slot = FWD_M;
        end else if (stage_writes(w_q, e_reg)) begin
          fwd_slot = FWD_W;
        end
      end
    end

    assign fwd_sel[i*2 +: 2] = fwd_slot;
  end

  // With forwarding only a load in E blocks; without it any in-flight writer does.
  assign hazard = FWD_EN ? (|lu_hit) : (|raw_hit);

  // Busy dominates everything (mispredict ignored while busy); a mispredict
  // then overrides the RAW/load-use stall.
  always_comb begin
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    multi_busy = 1'b0;
    if (reset) begin
      if (busy) begin
        stall_f    = 1'b1;
        stall_d    = 1'b1;
        stall_e    = 1'b1;
        multi_busy = 1'b1;
      end else if (br_missed_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (hazard) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_comb begin
    e_d       = '0;
    e_d.valid = dec_valid;
    e_d.dst   = STAGE_AW'(dec_dst);
    e_d.wr    = dec_wr;
    e_d.load  = dec_load;
  end

  hazard_stage_reg u_stage_e (
    .clk   (clk),
    .reset (reset),
    .hold  (stall_e),
    .flush (flush_e),
    .d     (e_d),
    .q     (e_q)
  );

  hazard_stage_reg u_stage_m (
    .clk   (clk),
    .reset (reset),
    .hold  (1'b0),
    .flush (busy),
    .d     (e_q),
    .q     (m_q)
  );

  hazard_stage_reg u_stage_w (
    .clk   (clk),
    .reset (reset),
    .hold  (1'b0),
    .flush (1'b0),
    .d     (m_q),
    .q     (w_q)
  );

  // Source operands of the E instruction follow the same hold/bubble rules
  // as the E mirror stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_src  <= '0;
      e_used <= '0;
    end else if (!stall_e) begin
      if (flush_e) begin
        e_src  <= '0;
        e_used <= '0;
      end else begin
        e_src  <= dec_src;
        e_used <= dec_src_used & {NSRC{dec_valid}};
      end
    end
  end

  // cnt counts the remaining busy cycles; a multi op entering E loads it,
  // so the op sits in E for MUL_LAT cycles in total.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
    end else if (!flush_e && dec_valid && dec_multi) begin
      cnt <= CNT_LOAD;
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: one forwarding and one no-forwarding instance
// share the decode inputs and are compared every cycle against a behavioural
// pipeline model; directed sequences pin the model with literal expectations.
module tb_hazard_scoreboard;

  localparam int AW = 4;
  localparam int NS = 3;
  localparam int ML = 3;

  typedef struct packed {
    logic           valid;
    logic [AW-1:0]  dst;
    logic           wr;
    logic           load;
    logic           multi;
    logic [NS*AW-1:0] src;
    logic [NS-1:0]  used;
  } minst_t;

  typedef struct packed {
    logic sf, sd, se, fd, fe, busy;
    logic [2*NS-1:0] fwd;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d_valid = 1'b0;
  logic [NS*AW-1:0] d_src = '0;
  logic [NS-1:0] d_used = '0;
  logic [AW-1:0] d_dst = '0;
  logic d_wr = 1'b0, d_load = 1'b0, d_multi = 1'b0, br = 1'b0;

  logic o1_sf, o1_sd, o1_se, o1_fd, o1_fe, o1_busy;
  logic [2*NS-1:0] o1_fwd;
  logic o0_sf, o0_sd, o0_se, o0_fd, o0_fe, o0_busy;
  logic [2*NS-1:0] o0_fwd;

  int total = 0;
  int bad = 0;

  minst_t mst [2][3];
  int unsigned age [2];
  out_t exp_o [2];

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(AW), .NSRC(NS), .MUL_LAT(ML), .FWD_EN(1'b1)) dut1 (
    .clk(clk), .reset(rst), .dec_valid(d_valid), .dec_src(d_src), .dec_src_used(d_used),
    .dec_dst(d_dst), .dec_wr(d_wr), .dec_load(d_load), .dec_multi(d_multi),
    .br_missed_e(br), .stall_f(o1_sf), .stall_d(o1_sd), .stall_e(o1_se),
    .flush_d(o1_fd), .flush_e(o1_fe), .fwd_sel(o1_fwd), .multi_busy(o1_busy));

  hazard_scoreboard #(.REG_AW(AW), .NSRC(NS), .MUL_LAT(ML), .FWD_EN(1'b0)) dut0 (
    .clk(clk), .reset(rst), .dec_valid(d_valid), .dec_src(d_src), .dec_src_used(d_used),
    .dec_dst(d_dst), .dec_wr(d_wr), .dec_load(d_load), .dec_multi(d_multi),
    .br_missed_e(br), .stall_f(o0_sf), .stall_d(o0_sd), .stall_e(o0_se),
    .flush_d(o0_fd), .flush_e(o0_fe), .fwd_sel(o0_fwd), .multi_busy(o0_busy));

  function automatic logic writes(input minst_t s, input logic [AW-1:0] r);
    return s.valid && s.wr && (s.dst == r);
  endfunction

  // k = 1: forwarding instance, k = 0: stall-only instance.
  function automatic out_t model_out(input int k);
    out_t o;
    minst_t e, m, w;
    logic hz, busy;
    logic [AW-1:0] r;
    o = '0;
    if (!rst) return o;
    e = mst[k][0];
    m = mst[k][1];
    w = mst[k][2];
    busy = e.valid && e.multi && (age[k] < ML - 1);
    hz = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (d_valid && d_used[i]) begin
        r = d_src[i*AW +: AW];
        if (k == 1) hz = hz | (e.load && writes(e, r));
        else        hz = hz | writes(e, r) | writes(m, r) | writes(w, r);
      end
    end
    if (busy) begin
      o.sf = 1'b1; o.sd = 1'b1; o.se = 1'b1; o.busy = 1'b1;
    end else if (br) begin
      o.fd = 1'b1; o.fe = 1'b1;
    end else if (hz) begin
      o.sf = 1'b1; o.sd = 1'b1; o.fe = 1'b1;
    end
    if (k == 1 && e.valid) begin
      for (int i = 0; i < NS; i++) begin
        if (e.used[i]) begin
          r = e.src[i*AW +: AW];
          if (writes(m, r))      o.fwd[i*2 +: 2] = 2'b10;
          else if (writes(w, r)) o.fwd[i*2 +: 2] = 2'b01;
        end
      end
    end
    return o;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) mst[k][s] = '0;
      age[k] = 0;
    end
  endtask

  task automatic model_advance();
    minst_t dn;
    if (!rst) begin
      model_clear();
      return;
    end
    dn = '{valid: d_valid, dst: d_dst, wr: d_wr, load: d_load, multi: d_multi,
           src: d_src, used: d_used};
    for (int k = 0; k < 2; k++) begin
      mst[k][2] = mst[k][1];
      if (exp_o[k].busy) begin
        mst[k][1] = '0;
        age[k] = age[k] + 1;
      end else begin
        mst[k][1] = mst[k][0];
        if (exp_o[k].fe || !d_valid) mst[k][0] = '0;
        else                         mst[k][0] = dn;
        age[k] = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // Let inputs settle, then compare both instances with the model.
  task automatic apply();
    #1;
    if (!rst) model_clear();
    for (int k = 0; k < 2; k++) exp_o[k] = model_out(k);
    chk("model_fwd", 32'({o1_sf, o1_sd, o1_se, o1_fd, o1_fe, o1_busy, o1_fwd}), 32'(exp_o[1]));
    chk("model_nofwd", 32'({o0_sf, o0_sd, o0_se, o0_fd, o0_fe, o0_busy, o0_fwd}), 32'(exp_o[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic set_d(input logic v, input logic [AW-1:0] dst, input logic wr,
                       input logic ld, input logic mul, input logic [AW-1:0] s0,
                       input logic [NS-1:0] used);
    d_valid = v; d_dst = dst; d_wr = wr; d_load = ld; d_multi = mul;
    d_src = '0;
    d_src[AW-1:0] = s0;
    d_used = used;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      set_d(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
      apply();
      tick();
    end
  endtask

  int cnt_stall;
  int cnt_busy;

  initial begin
    model_clear();
    exp_o[0] = '0;
    exp_o[1] = '0;
    @(negedge clk);
    apply();
    chk("reset_outputs", 32'({o1_sf, o1_sd, o1_se, o1_fd, o1_fe, o1_busy, o1_fwd}), 32'd0);
    tick();
    rst = 1'b1;
    nops(1);

    // ADD r1 in E, SUB r1 in D, then SUB in E forwards from M.
    set_d(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, '0, '0); apply(); tick();
    set_d(1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 4'd1, 3'b001); apply();
    chk("add_sub_nostall", 32'({o1_sf, o1_sd, o1_se, o1_fe}), 32'd0);
    tick();
    set_d(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0); apply();
    chk("add_sub_fwd_m", 32'(o1_fwd), 32'b000010);
    tick();
    nops(3);

    // LDR r2 then dependent ORR r2.
    set_d(1'b1, 4'd2, 1'b1, 1'b1, 1'b0, '0, '0); apply(); tick();
    set_d(1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 4'd2, 3'b001); apply();
    chk("load_use_stall", 32'({o1_sf, o1_sd, o1_se, o1_fd, o1_fe}), 32'b11001);
    tick();
    apply();
    chk("load_use_release", 32'({o1_sf, o1_sd, o1_se, o1_fd, o1_fe}), 32'd0);
    tick();
    set_d(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0); apply();
    chk("load_use_fwd_w", 32'(o1_fwd), 32'b000001);
    tick();
    nops(3);

    // MUL r5 then ADD reading r5.
    set_d(1'b1, 4'd5, 1'b1, 1'b0, 1'b1, '0, '0); apply(); tick();
    set_d(1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 4'd5, 3'b001);
    cnt_busy = 0;
    for (int i = 0; i < 2; i++) begin
      apply();
      if (o1_busy && o1_se) cnt_busy++;
      tick();
    end
    apply();
    chk("mul_busy_cycles", 32'(cnt_busy), 32'd2);
    chk("mul_released", 32'({o1_busy, o1_se, o1_sd}), 32'd0);
    tick();
    set_d(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0); apply();
    chk("mul_next_in_e", 32'(o1_fwd), 32'b000010);
    tick();
    nops(3);

    // Mispredict together with a load-use.
    set_d(1'b1, 4'd2, 1'b1, 1'b1, 1'b0, '0, '0); apply(); tick();
    set_d(1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 4'd2, 3'b001);
    br = 1'b1;
    apply();
    chk("br_over_load_use", 32'({o1_sf, o1_sd, o1_se, o1_fd, o1_fe}), 32'b00011);
    tick();
    br = 1'b0;
    nops(3);

    // No-forward mode: ADD r3 then AND r3 stalls for three cycles.
    set_d(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, '0, '0); apply(); tick();
    set_d(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 4'd3, 3'b001);
    cnt_stall = 0;
    for (int i = 0; i < 6; i++) begin
      apply();
      if (!o0_sd) break;
      cnt_stall++;
      tick();
    end
    chk("nofwd_stall_len", 32'(cnt_stall), 32'd3);
    tick();
    set_d(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0); apply();
    chk("nofwd_fwd_zero", 32'(o0_fwd), 32'd0);
    tick();
    nops(3);

    // Reset during the second busy cycle of a MUL.
    set_d(1'b1, 4'd5, 1'b1, 1'b0, 1'b1, '0, '0); apply(); tick();
    set_d(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0); apply(); tick();
    apply();
    chk("mul_busy_2nd", 32'(o1_busy), 32'd1);
    rst = 1'b0;
    apply();
    chk("reset_mid_fwd", 32'({o1_sf, o1_sd, o1_se, o1_fd, o1_fe, o1_busy, o1_fwd}), 32'd0);
    chk("reset_mid_nofwd", 32'({o0_sf, o0_sd, o0_se, o0_fd, o0_fe, o0_busy, o0_fwd}), 32'd0);
    tick();
    rst = 1'b1;
    apply();
    chk("after_reset_idle", 32'({o1_busy, o1_se, o0_busy}), 32'd0);
    tick();

    // Randomised traffic over a small register set to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) != 0);
      d_valid = ($urandom_range(0, 3) != 0);
      d_dst = AW'($urandom_range(0, 3));
      d_wr = ($urandom_range(0, 3) != 0);
      d_load = ($urandom_range(0, 3) == 0);
      d_multi = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NS; i++) d_src[i*AW +: AW] = AW'($urandom_range(0, 3));
      d_used = NS'($urandom);
      br = ($urandom_range(0, 7) == 0);
      apply();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
